// File: rtl/irq_controller.sv
// Interrupt controller: rising-edge capture, mask/enable, fixed priority (0 highest), req/ack/rti handshake.
// Latency: irq_in edge -> pend next cycle -> irq_req one cycle later; pend bit clears at the ack edge.
// Backpressure: request is held frozen until ack; one source in service, others wait in pend until rti.
module irq_controller #(
   parameter int          NUM_IRQ    = 4,
   parameter int          PMA_SIZE   = 16,
   parameter int unsigned VEC_BASE   = 32'h0010,
   parameter int unsigned VEC_STRIDE = 4,
   localparam int         IDW        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_IRQ-1:0]  irq_in,
   input  logic                cfg_we,
   input  logic [1:0]          cfg_sel,
   input  logic [NUM_IRQ-1:0]  cfg_wdata,
   input  logic                ps_idle,
   input  logic                irq_ack,
   input  logic                irq_rti,
   output logic                irq_req,
   output logic [PMA_SIZE-1:0] irq_vec,
   output logic                irq_active,
   output logic [IDW-1:0]      irq_id,
   output logic [NUM_IRQ-1:0]  irq_pend,
   output logic [NUM_IRQ-1:0]  irq_mask,
   output logic [NUM_IRQ-1:0]  irq_lost,
   output logic                irq_wake
);

   typedef enum logic [1:0] {
      S_WAIT    = 2'd0,
      S_REQ     = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [NUM_IRQ-1:0]   prev;
   logic [NUM_IRQ-1:0]   rise;
   logic [NUM_IRQ-1:0]   clr;
   logic [NUM_IRQ-1:0]   avail;
   logic [NUM_IRQ-1:0]   lost_set;
   logic [NUM_IRQ-1:0]   lost_clr;
   logic                 global_en;
   logic                 capture;
   logic                 sel_vld;
   logic [IDW-1:0]       sel_id;
   logic [PMA_SIZE-1:0]  sel_vec;

   assign rise     = irq_in & ~prev;
   assign avail    = irq_pend & irq_mask;
   // An edge on a source that is still pending (and not being acked now) is an overrun.
   assign lost_set = rise & irq_pend & ~clr;
   assign lost_clr = (cfg_we && cfg_sel == 2'd2) ? cfg_wdata : '0;
   assign irq_req    = (state == S_REQ);
   assign irq_active = (state == S_SERVICE);
   assign irq_wake   = ps_idle & global_en & (|avail);

   // Fixed-priority pick: lowest index among enabled pending sources wins.
   always_comb begin
      sel_id  = '0;
      sel_vld = 1'b0;
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
         if (avail[k]) begin
            sel_id  = IDW'(k);
            sel_vld = 1'b1;
         end
      end
      sel_vec = PMA_SIZE'(VEC_BASE) + PMA_SIZE'(sel_id) * PMA_SIZE'(VEC_STRIDE);
   end

   // Handshake FSM next state; ack wins over a simultaneous rti in every state.
   always_comb begin
      state_nxt = state;
      clr       = '0;
      capture   = 1'b0;
      case (state)
         S_WAIT: begin
            if (global_en && sel_vld) begin
               state_nxt = S_REQ;
               capture   = 1'b1;
            end
         end
         S_REQ: begin
            if (irq_ack) begin
               state_nxt   = S_SERVICE;
               clr[irq_id] = 1'b1;
            end
         end
         S_SERVICE: begin
            if (irq_rti && !irq_ack) begin
               state_nxt = S_WAIT;
            end
         end
         default: state_nxt = S_WAIT;
      endcase
   end

   // State register plus id/vector latched on entry to REQ so the request stays frozen.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= S_WAIT;
         irq_id  <= '0;
         irq_vec <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            irq_id  <= sel_id;
            irq_vec <= sel_vec;
         end
      end
   end

   // Edge history, pending and sticky lost flags; a new edge beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         prev     <= '0;
         irq_pend <= '0;
         irq_lost <= '0;
      end else begin
         prev     <= irq_in;
         irq_pend <= (irq_pend & ~clr) | rise;
         irq_lost <= (irq_lost & ~lost_clr) | lost_set;
      end
   end

   // Software configuration: mask and global enable.
   always_ff @(posedge clk) begin
      if (!reset) begin
         irq_mask  <= '0;
         global_en <= 1'b0;
      end else if (cfg_we) begin
         case (cfg_sel)
            2'd0:    irq_mask  <= cfg_wdata;
            2'd1:    global_en <= cfg_wdata[0];
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: expected vectors queued at stimulus time, popped when irq_req rises.
// Inputs driven 1 time unit after posedge, outputs sampled there or at negedge.
// Every wait on the DUT is bounded; a timeout counts as a failed check.
module tb_irq_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  irq_in;
   logic        cfg_we;
   logic [1:0]  cfg_sel;
   logic [3:0]  cfg_wdata;
   logic        ps_idle;
   logic        irq_ack;
   logic        irq_rti;
   logic        irq_req;
   logic [15:0] irq_vec;
   logic        irq_active;
   logic [1:0]  irq_id;
   logic [3:0]  irq_pend;
   logic [3:0]  irq_mask;
   logic [3:0]  irq_lost;
   logic        irq_wake;

   typedef struct {
      logic [15:0] vec;
      logic [1:0]  id;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   logic req_seen = 1'b0;

   irq_controller dut (
      .clk        (clk),
      .reset      (reset),
      .irq_in     (irq_in),
      .cfg_we     (cfg_we),
      .cfg_sel    (cfg_sel),
      .cfg_wdata  (cfg_wdata),
      .ps_idle    (ps_idle),
      .irq_ack    (irq_ack),
      .irq_rti    (irq_rti),
      .irq_req    (irq_req),
      .irq_vec    (irq_vec),
      .irq_active (irq_active),
      .irq_id     (irq_id),
      .irq_pend   (irq_pend),
      .irq_mask   (irq_mask),
      .irq_lost   (irq_lost),
      .irq_wake   (irq_wake)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [1:0] sel, input logic [3:0] data);
      cfg_we    = 1'b1;
      cfg_sel   = sel;
      cfg_wdata = data;
      tick();
      cfg_we    = 1'b0;
   endtask

   task automatic ack();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   task automatic rti();
      irq_rti = 1'b1;
      tick();
      irq_rti = 1'b0;
   endtask

   task automatic push(input logic [15:0] vec, input logic [1:0] id);
      exp_t e;
      e.vec = vec;
      e.id  = id;
      exp_q.push_back(e);
   endtask

   task automatic wait_req();
      int n = 0;
      while (!irq_req && n < 20) begin
         tick();
         n++;
      end
      if (!irq_req) check("req_timeout", 32'd0, 32'd1);
      #5;
   endtask

   // Scoreboard monitor: each new request is compared against the oldest expected entry.
   initial begin
      forever begin
         @(negedge clk);
         if (irq_req && !req_seen) begin
            if (exp_q.size() == 0) begin
               check("unexpected_req", {16'd0, irq_vec}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_vec", {16'd0, irq_vec}, {16'd0, e.vec});
               check("sb_id", {30'd0, irq_id}, {30'd0, e.id});
            end
         end
         req_seen = irq_req;
      end
   end

   initial begin
      reset = 1'b0; irq_in = '0; cfg_we = 1'b0; cfg_sel = '0; cfg_wdata = '0;
      ps_idle = 1'b0; irq_ack = 1'b0; irq_rti = 1'b0;
      tick(); tick();
      check("rst_req", {31'd0, irq_req}, 32'd0);
      check("rst_vec", {16'd0, irq_vec}, 32'd0);
      check("rst_active", {31'd0, irq_active}, 32'd0);
      check("rst_id", {30'd0, irq_id}, 32'd0);
      check("rst_pend", {28'd0, irq_pend}, 32'd0);
      check("rst_mask", {28'd0, irq_mask}, 32'd0);
      check("rst_lost", {28'd0, irq_lost}, 32'd0);
      reset = 1'b1;

      // 1: single source, latency and full handshake
      cfg(2'd0, 4'b1111);
      cfg(2'd1, 4'b0001);
      check("mask_wr", {28'd0, irq_mask}, 32'hF);
      push(16'h0018, 2'd2);
      irq_in = 4'b0100;
      tick();
      irq_in = 4'b0000;
      check("t1_pend", {28'd0, irq_pend}, 32'h4);
      check("t1_req_e0", {31'd0, irq_req}, 32'd0);
      tick();
      check("t1_req_e1", {31'd0, irq_req}, 32'd1);
      #5;
      ack();
      check("t1_pend_clr", {28'd0, irq_pend}, 32'h0);
      check("t1_active", {31'd0, irq_active}, 32'd1);
      check("t1_req_drop", {31'd0, irq_req}, 32'd0);
      rti();
      check("t1_rti", {31'd0, irq_active}, 32'd0);

      // 2: two simultaneous sources, priority order
      push(16'h0014, 2'd1);
      push(16'h001C, 2'd3);
      irq_in = 4'b1010;
      tick();
      irq_in = 4'b0000;
      wait_req();
      ack(); rti();
      wait_req();
      check("t2_id3", {30'd0, irq_id}, 32'd3);
      ack(); rti();

      // 3: masked source latches but does not request until unmasked
      cfg(2'd0, 4'b0000);
      irq_in = 4'b0001;
      tick();
      irq_in = 4'b0000;
      check("t3_pend", {28'd0, irq_pend}, 32'h1);
      ps_idle = 1'b1;
      #1;
      check("t3_wake_masked", {31'd0, irq_wake}, 32'd0);
      tick(); tick();
      check("t3_no_req", {31'd0, irq_req}, 32'd0);
      push(16'h0010, 2'd0);
      cfg(2'd0, 4'b0001);
      check("t3_req_early", {31'd0, irq_req}, 32'd0);
      check("t3_wake", {31'd0, irq_wake}, 32'd1);
      tick();
      check("t3_req", {31'd0, irq_req}, 32'd1);
      ps_idle = 1'b0;
      #5;
      ack(); rti();
      cfg(2'd0, 4'b1111);

      // 4: overrun while in service sets lost; W1C clears it
      push(16'h0018, 2'd2);
      irq_in = 4'b0100;
      tick();
      irq_in = 4'b0000;
      wait_req();
      ack();
      irq_in = 4'b0100; tick();
      irq_in = 4'b0000; tick();
      check("t4_lost_first", {28'd0, irq_lost}, 32'h0);
      irq_in = 4'b0100; tick();
      irq_in = 4'b0000; tick();
      check("t4_lost", {28'd0, irq_lost}, 32'h4);
      check("t4_pend", {28'd0, irq_pend}, 32'h4);
      check("t4_still_active", {31'd0, irq_active}, 32'd1);
      cfg(2'd2, 4'b0100);
      check("t4_lost_clr", {28'd0, irq_lost}, 32'h0);
      push(16'h0018, 2'd2);
      rti();
      wait_req();
      ack(); rti();

      // 5: request stays frozen when a higher priority edge arrives
      push(16'h001C, 2'd3);
      irq_in = 4'b1000;
      tick();
      irq_in = 4'b0000;
      wait_req();
      irq_in = 4'b0001; tick();
      irq_in = 4'b0000; tick();
      check("t5_vec_frozen", {16'd0, irq_vec}, 32'h1C);
      check("t5_id_frozen", {30'd0, irq_id}, 32'd3);
      check("t5_pend", {28'd0, irq_pend}, 32'h9);
      ack();
      check("t5_pend_ack", {28'd0, irq_pend}, 32'h1);
      push(16'h0010, 2'd0);
      rti();
      wait_req();
      ack();

      // 6: reset in service discards everything; stray strobes do nothing
      irq_in = 4'b1010; tick();
      irq_in = 4'b0000; tick();
      check("t6_pend", {28'd0, irq_pend}, 32'hA);
      check("t6_active", {31'd0, irq_active}, 32'd1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      ps_idle = 1'b1;
      #1;
      check("t6_req", {31'd0, irq_req}, 32'd0);
      check("t6_active0", {31'd0, irq_active}, 32'd0);
      check("t6_vec", {16'd0, irq_vec}, 32'd0);
      check("t6_id", {30'd0, irq_id}, 32'd0);
      check("t6_pend0", {28'd0, irq_pend}, 32'd0);
      check("t6_mask", {28'd0, irq_mask}, 32'd0);
      check("t6_wake", {31'd0, irq_wake}, 32'd0);
      ack();
      check("t6_sp_ack_req", {31'd0, irq_req}, 32'd0);
      check("t6_sp_ack_act", {31'd0, irq_active}, 32'd0);
      rti();
      check("t6_sp_rti_act", {31'd0, irq_active}, 32'd0);
      tick(); tick();
      check("sb_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller between external/peripheral interrupt sources and the program sequencer.
- Detects rising edges on NUM_IRQ request lines and latches them into a pending register.
- Applies a software-writable mask and global enable, then selects the highest-priority pending source.
- Runs a request/acknowledge/return handshake with the sequencer, handing it a vector address; one interrupt in service at a time, no nesting.

Parameters:
- NUM_IRQ, 4, number of interrupt sources; index 0 is highest priority.
- PMA_SIZE, 16, width of program-memory vector address.
- VEC_BASE, 16'h0010, vector address of source 0.
- VEC_STRIDE, 4, address distance between consecutive vectors.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low reset; sampled on rising clk.
- irq_in  in  NUM_IRQ  level interrupt lines, synchronous to clk.
- cfg_we  in  1  configuration write strobe.
- cfg_sel  in  2  0=mask register, 1=global enable (bit0), 2=clear lost flags (write-1-to-clear), 3=reserved (ignored).
- cfg_wdata  in  NUM_IRQ  configuration write data.
- ps_idle  in  1  sequencer is executing IDLE.
- irq_ack  in  1  sequencer has taken the vector (one-cycle pulse).
- irq_rti  in  1  sequencer executed return-from-interrupt (one-cycle pulse).
- irq_req  out  1  interrupt request to sequencer.
- irq_vec  out  PMA_SIZE  vector address; valid while irq_req=1.
- irq_active  out  1  an interrupt is in service.
- irq_id  out  clog2(NUM_IRQ)  index of requested/in-service source.
- irq_pend  out  NUM_IRQ  pending register.
- irq_mask  out  NUM_IRQ  mask register (1 = enabled).
- irq_lost  out  NUM_IRQ  sticky flag: edge arrived while the same source was already pending.
- irq_wake  out  1  combinational: ps_idle & global_en & |(irq_pend & irq_mask).

Behaviour:
- Reset (reset=0 at clk edge): pend=0, mask=0, global_en=0, lost=0, irq_in history=0, state=WAIT, irq_req=0, irq_vec=0, irq_active=0, irq_id=0. Reset mid-handshake discards everything, including the in-service interrupt.
- Edge detect: edge[k] = irq_in[k] & ~prev[k]; prev is registered every cycle.
- Pend update per edge: pend[k] <= (pend[k] & ~clr[k]) | edge[k]. Set wins over a same-cycle clear.
- Lost flag: lost[k] set when edge[k] & pend[k] & ~clr[k]. Cleared only by cfg_sel=2 write-1; a same-cycle set wins.
- Edges latch regardless of mask and global_en.
- State WAIT (irq_req=0, irq_active=0):
  - If global_en & |(pend & mask): go to REQ.
  - Capture irq_id = lowest set index of (pend & mask) and irq_vec = VEC_BASE + id*VEC_STRIDE, mod 2^PMA_SIZE.
- State REQ (irq_req=1):
  - irq_id and irq_vec are frozen; a later higher-priority edge, a mask change or a global_en change does not withdraw or alter the request.
  - On irq_ack: clr[irq_id]=1, state SERVICE, irq_req=0, irq_active=1.
- State SERVICE (irq_active=1, irq_id held):
  - On irq_rti: state WAIT, irq_active=0.
  - Pending sources wait; re-arbitration happens in WAIT the cycle after the return.
- Spurious strobes: irq_ack outside REQ and irq_rti outside SERVICE are ignored; simultaneous ack+rti is treated as ack only.
- Latency: irq_in rises before edge E0, so pend bit is set after E0; irq_req=1 after E1 (2 cycles); the bit clears at the ack edge.
- Config writes take effect at the next edge and are visible in WAIT arbitration in the following cycle.

Test Plan:
1. Reset, write mask=4'b1111, global_en=1; raise irq_in[2] -> irq_req=1 two cycles later, irq_vec=16'h0018, irq_id=2; ack -> pend[2]=0, irq_active=1; rti -> irq_active=0.
2. Raise irq_in[3] and irq_in[1] in the same cycle -> vec=16'h0014 (id 1); after ack+rti, id 3 is requested with vec=16'h001C.
3. mask=4'b0000, raise irq_in[0] -> pend[0]=1, irq_req stays 0, and irq_wake=1 only if global_en=1 and the mask allows it; write mask=4'b0001 -> request 2 cycles later.
4. While in SERVICE for id 2: pulse irq_in[2] twice (low between pulses) -> irq_lost[2]=1, pend[2]=1; cfg_sel=2 write 4'b0100 -> irq_lost[2]=0.
5. In REQ for id 3, raise irq_in[0] -> irq_vec stays 16'h001C until ack; id 0 is served after rti.
6. Assert reset during SERVICE with pend=4'b1010 -> all outputs 0 the next cycle; irq_ack/irq_rti pulses with no request pending produce no state change.
